// File: rtl/wwvb_pulse_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : wwvb_pulse_decoder                                          |
// | Description: Block-averages carrier magnitude, then times carrier-low    |
// |              pulses with hysteresis and classifies them as WWVB symbols. |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module wwvb_pulse_decoder #(
    parameter int unsigned AVG_LOG2   = 4,
    parameter logic [12:0] HI_TH      = 13'd1200,
    parameter logic [12:0] LO_TH      = 13'd600,
    parameter int unsigned T_MIN      = 10,
    parameter int unsigned T_ZERO_MAX = 35,
    parameter int unsigned T_ONE_MAX  = 65,
    parameter int unsigned T_MARK_MAX = 95
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [12:0] data_in,
    input  logic               data_strobe,
    output logic        [12:0] avg_mag,
    output logic               avg_valid,
    output logic               carrier_low,
    output logic        [1:0]  sym,
    output logic               sym_valid
);

    localparam int unsigned c_ACC_W = 13 + AVG_LOG2;
    localparam int unsigned c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [7:0] c_T_MIN      = 8'(T_MIN);
    localparam logic [7:0] c_T_ZERO_MAX = 8'(T_ZERO_MAX);
    localparam logic [7:0] c_T_ONE_MAX  = 8'(T_ONE_MAX);
    localparam logic [7:0] c_T_MARK_MAX = 8'(T_MARK_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    logic [c_ACC_W-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [12:0]        r_avg_mag;
    logic               r_avg_valid;
    state_t             r_state;
    logic [7:0]         r_len;
    logic [1:0]         r_sym;
    logic               r_sym_valid;

    logic [12:0]        w_mag;
    logic [c_ACC_W-1:0] w_sum;
    state_t             w_state_nx;
    logic [7:0]         w_len_nx;
    logic [1:0]         w_sym_nx;
    logic               w_sym_valid_nx;

    // Negating -4096 yields bit pattern 0x1000, which reads as 4096 unsigned.
    assign w_mag = data_in[12] ? 13'(-data_in) : 13'(data_in);
    assign w_sum = r_acc + c_ACC_W'(w_mag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg_mag   <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (data_strobe) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_avg_mag   <= w_sum[AVG_LOG2 +: 13];
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= 8'd0;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_len       <= w_len_nx;
            r_sym       <= w_sym_nx;
            r_sym_valid <= w_sym_valid_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_len_nx       = r_len;
        w_sym_nx       = r_sym;
        w_sym_valid_nx = 1'b0;
        if (r_avg_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (r_avg_mag >= HI_TH) w_state_nx = S_HIGH;
                end
                S_HIGH: begin
                    if (r_avg_mag < LO_TH) begin
                        w_state_nx = S_LOW;
                        w_len_nx   = 8'd1;
                    end
                end
                S_LOW: begin
                    if (r_avg_mag >= HI_TH) begin
                        w_state_nx = S_HIGH;
                        w_len_nx   = 8'd0;
                        if (r_len >= c_T_MIN) begin
                            w_sym_valid_nx = 1'b1;
                            if (r_len <= c_T_ZERO_MAX)     w_sym_nx = 2'b00;
                            else if (r_len <= c_T_ONE_MAX) w_sym_nx = 2'b01;
                            else if (r_len <= c_T_MARK_MAX) w_sym_nx = 2'b10;
                            else                           w_sym_nx = 2'b11;
                        end
                    end else if (r_len == c_T_MARK_MAX) begin
                        // Pulse overran the marker limit: report once, then
                        // require fresh carrier before timing another pulse.
                        w_state_nx     = S_IDLE;
                        w_len_nx       = 8'd0;
                        w_sym_nx       = 2'b11;
                        w_sym_valid_nx = 1'b1;
                    end else begin
                        w_len_nx = r_len + 8'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_len_nx   = 8'd0;
                end
            endcase
        end
    end

    assign avg_mag     = r_avg_mag;
    assign avg_valid   = r_avg_valid;
    assign carrier_low = (r_state == S_LOW);
    assign sym         = r_sym;
    assign sym_valid   = r_sym_valid;

endmodule
`default_nettype wire
